// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 timing constants and display FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 751;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        DISPLAY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// Module      : vga_timing
// Description : Pixel divider, h/v raster counters and raw sync/visible flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int H_W     = $clog2(H_VIS + H_FP + H_SYNC + H_BP),
    parameter int V_W     = $clog2(V_VIS + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           reset,
    output logic           tick,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           visible,
    output logic           hsync_raw,
    output logic           vsync_raw,
    output logic           frame_wrap,
    output logic           vga_clk
);

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);

    localparam logic [H_W-1:0] c_h_last   = H_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [H_W-1:0] c_h_vis    = H_W'(H_VIS);
    localparam logic [H_W-1:0] c_h_sync_s = H_W'(H_VIS + H_FP);
    localparam logic [H_W-1:0] c_h_sync_e = H_W'(H_VIS + H_FP + H_SYNC - 1);

    localparam logic [V_W-1:0] c_v_last   = V_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [V_W-1:0] c_v_vis    = V_W'(V_VIS);
    localparam logic [V_W-1:0] c_v_sync_s = V_W'(V_VIS + V_FP);
    localparam logic [V_W-1:0] c_v_sync_e = V_W'(V_VIS + V_FP + V_SYNC - 1);

    logic [c_div_w-1:0] r_div;
    logic [c_div_w-1:0] w_div_next;
    logic [H_W-1:0]     r_h_cnt;
    logic [V_W-1:0]     r_v_cnt;
    logic               r_vga_clk;
    logic               w_tick;

    assign w_tick     = (r_div == c_div_last);
    assign w_div_next = w_tick ? '0 : r_div + 1'b1;

    // vga_clk is registered from the next divider value so it is high
    // for the first half of each pixel period yet still resets to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div     <= w_div_next;
            r_vga_clk <= (w_div_next < c_div_half);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign tick       = w_tick;
    assign h_cnt      = r_h_cnt;
    assign v_cnt      = r_v_cnt;
    assign vga_clk    = r_vga_clk;
    assign visible    = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
    assign hsync_raw  = !((r_h_cnt >= c_h_sync_s) && (r_h_cnt <= c_h_sync_e));
    assign vsync_raw  = !((r_v_cnt >= c_v_sync_s) && (r_v_cnt <= c_v_sync_e));
    assign frame_wrap = w_tick && (r_h_cnt == c_h_last) && (r_v_cnt == c_v_last);

endmodule

`default_nettype wire

// File: rtl/vga_frame_reader.sv
// ============================================================================
// Module      : vga_frame_reader
// Description : Scans the processed image memory onto a 640x480 VGA DAC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int X_OFF   = 192,
    parameter int Y_OFF   = 112,
    parameter int ADR_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             show,
    output logic [ADR_W-1:0] mem_adr,
    input  logic [7:0]       mem_data,
    output logic             vga_clk,
    output logic             hsync,
    output logic             vsync,
    output logic             blank_n,
    output logic             sync_n,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             frame_done
);

    localparam int c_h_w = $clog2(H_VIS + H_FP + H_SYNC + H_BP);
    localparam int c_v_w = $clog2(V_VIS + V_FP + V_SYNC + V_BP);

    localparam logic [c_h_w-1:0] c_x_lo = c_h_w'(X_OFF);
    localparam logic [c_h_w-1:0] c_x_hi = c_h_w'(X_OFF + IMG_W);
    localparam logic [c_v_w-1:0] c_y_lo = c_v_w'(Y_OFF);
    localparam logic [c_v_w-1:0] c_y_hi = c_v_w'(Y_OFF + IMG_H);

    localparam logic [ADR_W-1:0] c_x_adr   = ADR_W'(X_OFF);
    localparam logic [ADR_W-1:0] c_y_adr   = ADR_W'(Y_OFF);
    localparam logic [ADR_W-1:0] c_img_w_a = ADR_W'(IMG_W);

    logic             w_tick;
    logic [c_h_w-1:0] w_h_cnt;
    logic [c_v_w-1:0] w_v_cnt;
    logic             w_visible;
    logic             w_hsync_raw;
    logic             w_vsync_raw;
    logic             w_frame_wrap;
    logic             w_in_img;
    logic [ADR_W-1:0] w_adr;

    state_t           r_state;
    logic             r_frame_done;

    logic [ADR_W-1:0] r_mem_adr;
    logic             r_s1_in_img;
    logic             r_s1_visible;
    logic             r_s1_hsync;
    logic             r_s1_vsync;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_blank_n;
    logic [7:0]       r_pix;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .H_W     (c_h_w),
        .V_W     (c_v_w)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .tick       (w_tick),
        .h_cnt      (w_h_cnt),
        .v_cnt      (w_v_cnt),
        .visible    (w_visible),
        .hsync_raw  (w_hsync_raw),
        .vsync_raw  (w_vsync_raw),
        .frame_wrap (w_frame_wrap),
        .vga_clk    (vga_clk)
    );

    assign w_in_img = (w_h_cnt >= c_x_lo) && (w_h_cnt < c_x_hi) &&
                      (w_v_cnt >= c_y_lo) && (w_v_cnt < c_y_hi);

    assign w_adr = (ADR_W'(w_v_cnt) - c_y_adr) * c_img_w_a + (ADR_W'(w_h_cnt) - c_x_adr);

    // State changes only on frame boundaries so a frame is never torn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (show && (w_h_cnt == '0) && (w_v_cnt == '0)) begin
                            r_state <= DISPLAY;
                        end
                    end
                    DISPLAY: begin
                        if (w_frame_wrap) begin
                            r_frame_done <= 1'b1;
                            if (!show) begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Stage 1: issue the read and delay the raw timing alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_adr    <= '0;
            r_s1_in_img  <= 1'b0;
            r_s1_visible <= 1'b0;
            r_s1_hsync   <= 1'b1;
            r_s1_vsync   <= 1'b1;
        end else if (w_tick) begin
            r_mem_adr    <= (w_in_img && (r_state == DISPLAY)) ? w_adr : '0;
            r_s1_in_img  <= w_in_img;
            r_s1_visible <= w_visible;
            r_s1_hsync   <= w_hsync_raw;
            r_s1_vsync   <= w_vsync_raw;
        end
    end

    // Stage 2: mem_data has settled a full pixel period after the address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
            r_pix     <= '0;
        end else if (w_tick) begin
            r_hsync   <= r_s1_hsync;
            r_vsync   <= r_s1_vsync;
            r_blank_n <= r_s1_visible;
            r_pix     <= (r_s1_in_img && (r_state == DISPLAY)) ? mem_data : 8'h00;
        end
    end

    assign mem_adr    = r_mem_adr;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign blank_n    = r_blank_n;
    assign sync_n     = 1'b0;
    assign red        = r_pix;
    assign green      = r_pix;
    assign blue       = r_pix;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
// ============================================================================
// Module      : tb_vga_frame_reader
// Description : Directed bench on a shrunken 60x37 raster with a 16x8 image.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_frame_reader;

    // Raster 60x37 ticks: hsync low h=44..51, vsync low v=32..33,
    // image at h=12..27, v=7..14, one frame = 2220 ticks = 4440 clks.
    localparam int H_TOT = 60;
    localparam int F_TICKS = 2220;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       show = 1'b0;
    logic [6:0] mem_adr;
    logic [7:0] mem_data = 8'h00;
    logic       vga_clk, hsync, vsync, blank_n, sync_n, frame_done;
    logic [7:0] red, green, blue;

    int clks = 0;
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    vga_frame_reader #(
        .CLK_DIV (2),
        .H_VIS (40), .H_FP (4), .H_SYNC (8), .H_BP (8),
        .V_VIS (30), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .IMG_W (16), .IMG_H (8), .X_OFF (12), .Y_OFF (7),
        .ADR_W (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .show       (show),
        .mem_adr    (mem_adr),
        .mem_data   (mem_data),
        .vga_clk    (vga_clk),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank_n    (blank_n),
        .sync_n     (sync_n),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) clks <= 0;
        else       clks <= clks + 1;
    end

    always @(posedge clk) mem_data <= {1'b0, mem_adr};

    always @(posedge clk) begin
        if (!reset && frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [31:0] exp);
        check_eq({tag, ".r"}, 32'(red), exp);
        check_eq({tag, ".g"}, 32'(green), exp);
        check_eq({tag, ".b"}, 32'(blue), exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".hsync"}, 32'(hsync), 1);
        check_eq({tag, ".vsync"}, 32'(vsync), 1);
        check_eq({tag, ".blank_n"}, 32'(blank_n), 0);
        check_eq({tag, ".mem_adr"}, 32'(mem_adr), 0);
        check_eq({tag, ".frame_done"}, 32'(frame_done), 0);
        check_eq({tag, ".vga_clk"}, 32'(vga_clk), 0);
        check_rgb(tag, 0);
    endtask

    function automatic int px(input int f, input int h, input int v);
        return f * F_TICKS + v * H_TOT + h;
    endfunction

    // Lands #1 after the clock edge that carries tick k since reset release.
    task automatic step_to(input int k);
        while (clks < 2 * k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int hs_low, vs_low, bl_hi, nz;

        repeat (5) begin
            @(posedge clk);
            #1;
            check_reset_outputs("rst_hold");
        end
        check_eq("sync_n", 32'(sync_n), 0);
        @(negedge clk);
        reset = 1'b0;

        // Frame 0, show low: outputs of ticks 2..2221 cover pixels 0..2219.
        step_to(2);
        hs_low = 0; vs_low = 0; bl_hi = 0; nz = 0;
        for (int i = 0; i < 2 * F_TICKS; i++) begin
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (blank_n) bl_hi++;
            if ((red | green | blue) != 8'h00 || mem_adr != 7'd0) nz++;
            @(posedge clk);
            #1;
        end
        check_eq("idle_hsync_low_clks", hs_low, 592);
        check_eq("idle_vsync_low_clks", vs_low, 240);
        check_eq("idle_blank_hi_clks", bl_hi, 2400);
        check_eq("idle_nonzero_data", nz, 0);

        // Frame 1: hsync edges with 2-tick latency, then show rises mid-image.
        step_to(px(1, 43, 0) + 2); check_eq("hs_pre_edge", 32'(hsync), 1);
        step_to(px(1, 44, 0) + 2); check_eq("hs_first_low", 32'(hsync), 0);
        step_to(px(1, 51, 0) + 2); check_eq("hs_last_low", 32'(hsync), 0);
        step_to(px(1, 52, 0) + 2); check_eq("hs_after", 32'(hsync), 1);
        step_to(px(1, 0, 10));
        show = 1'b1;
        step_to(px(1, 20, 12) + 1); check_eq("midframe_show_adr", 32'(mem_adr), 0);
        step_to(px(1, 20, 12) + 2); check_rgb("midframe_show_rgb", 0);

        // Frame 2: displayed.
        step_to(px(2, 12, 7) + 1);  check_eq("adr_first", 32'(mem_adr), 0);
        step_to(px(2, 13, 7) + 1);  check_eq("adr_second", 32'(mem_adr), 1);
        step_to(px(2, 20, 7) + 2);  check_rgb("rgb_20_7", 8);
        check_eq("blank_20_7", 32'(blank_n), 1);
        check_eq("hsync_20_7", 32'(hsync), 1);
        step_to(px(2, 27, 7) + 1);  check_eq("adr_row_end", 32'(mem_adr), 15);
        step_to(px(2, 12, 8) + 1);  check_eq("adr_row2", 32'(mem_adr), 16);
        step_to(px(2, 5, 9) + 1);   check_eq("outside_adr", 32'(mem_adr), 0);
        step_to(px(2, 5, 9) + 2);   check_rgb("outside_rgb", 0);
        check_eq("outside_blank", 32'(blank_n), 1);
        step_to(px(2, 20, 12) + 2); check_rgb("rgb_20_12", 88);
        step_to(px(2, 27, 14) + 1); check_eq("adr_last", 32'(mem_adr), 127);
        step_to(px(2, 0, 20));
        show = 1'b0;
        step_to(px(2, 0, 31) + 2);  check_eq("vs_pre", 32'(vsync), 1);
        step_to(px(2, 0, 32) + 2);  check_eq("vs_low", 32'(vsync), 0);
        step_to(px(3, 0, 0));       check_eq("frame_done_hi", 32'(frame_done), 1);
        @(posedge clk);
        #1;
        check_eq("frame_done_lo", 32'(frame_done), 0);

        // Frame 3: back in IDLE, syncs still running.
        step_to(px(3, 44, 1) + 2);  check_eq("idle_hsync", 32'(hsync), 0);
        step_to(px(3, 20, 7) + 1);  check_eq("idle_adr", 32'(mem_adr), 0);
        step_to(px(3, 20, 7) + 2);  check_rgb("idle_rgb", 0);
        check_eq("idle_blank", 32'(blank_n), 1);
        step_to(px(3, 0, 20));
        show = 1'b1;

        // Frame 4: displayed, then an asynchronous reset mid-frame.
        step_to(px(4, 20, 10) + 2); check_rgb("rgb_20_10", 56);
        check_eq("frame_done_count", done_cnt, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        step_to(px(0, 43, 0) + 2);  check_eq("rst_hs_pre", 32'(hsync), 1);
        step_to(px(0, 44, 0) + 2);  check_eq("rst_hs_low", 32'(hsync), 0);
        step_to(px(0, 20, 7) + 2);  check_rgb("rst_rgb_20_7", 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
